// File: rtl/alu_vector_engine.sv
// Vector ALU engine: two operand banks walked element by element through an ALU,
// one registered result per element streamed out over a valid/ready handshake.
module alu_vector_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_a,
    input  logic [ADDR_WIDTH-1:0] wr_addr_a,
    input  logic [DATA_WIDTH-1:0] wr_data_a,
    input  logic                  wr_en_b,
    input  logic [ADDR_WIDTH-1:0] wr_addr_b,
    input  logic [DATA_WIDTH-1:0] wr_data_b,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_opcode,
    input  logic [ADDR_WIDTH-1:0] cmd_base_a,
    input  logic [ADDR_WIDTH-1:0] cmd_base_b,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_carry,
    output logic                  res_last,
    output logic                  busy
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_OUT} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_b [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_a;
    logic [DATA_WIDTH-1:0] r_rd_b;
    logic [3:0]            r_opcode;
    logic [ADDR_WIDTH-1:0] r_base_a;
    logic [ADDR_WIDTH-1:0] r_base_b;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_chain;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_res_carry;
    logic                  r_res_last;
    logic [ADDR_WIDTH-1:0] w_addr_a;
    logic [ADDR_WIDTH-1:0] w_addr_b;
    logic [DATA_WIDTH:0]   w_full;
    logic [DATA_WIDTH:0]   w_cin;
    logic                  w_accept;
    logic                  w_at_last;

    // Address sums are ADDR_WIDTH wide, so wrap at DEPTH comes for free.
    assign w_addr_a  = r_base_a + r_idx;
    assign w_addr_b  = r_base_b + r_idx;
    assign w_cin     = {{DATA_WIDTH{1'b0}}, r_chain};
    assign w_at_last = (r_idx == r_len);
    assign cmd_ready = (r_state == S_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;
    assign busy      = (r_state != S_IDLE);
    assign res_valid = (r_state == S_OUT);
    assign res_data  = r_res_data;
    assign res_carry = r_res_carry;
    assign res_last  = r_res_last;

    // Banks are never cleared; the read is unconditional and only consumed after READ.
    always_ff @(posedge clk) begin
        if (wr_en_a) r_mem_a[wr_addr_a] <= wr_data_a;
        if (wr_en_b) r_mem_b[wr_addr_b] <= wr_data_b;
        r_rd_a <= r_mem_a[w_addr_a];
        r_rd_b <= r_mem_b[w_addr_b];
    end

    always_comb begin
        w_full = '0;
        case (r_opcode)
            4'd0: w_full = {1'b0, r_rd_a} + {1'b0, r_rd_b};
            4'd1: w_full = {1'b0, r_rd_a} - {1'b0, r_rd_b};
            4'd2: w_full = {1'b0, r_rd_a & r_rd_b};
            4'd3: w_full = {1'b0, r_rd_a | r_rd_b};
            4'd4: w_full = {1'b0, r_rd_a ^ r_rd_b};
            4'd5: w_full = {1'b0, ~r_rd_a};
            4'd6: w_full = {r_rd_a, 1'b0};
            4'd7: w_full = {r_rd_a[0], 1'b0, r_rd_a[DATA_WIDTH-1:1]};
            // Two's-complement wrap leaves the borrow in the top bit.
            4'd8: w_full = {1'b0, r_rd_a} + {1'b0, r_rd_b} + w_cin;
            4'd9: w_full = {1'b0, r_rd_a} - {1'b0, r_rd_b} - w_cin;
            default: w_full = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_READ;
            S_READ: w_state_next = S_EXEC;
            S_EXEC: w_state_next = S_OUT;
            S_OUT:  if (res_ready) w_state_next = w_at_last ? S_IDLE : S_READ;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_opcode    <= '0;
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_chain     <= 1'b0;
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_opcode <= cmd_opcode;
                r_base_a <= cmd_base_a;
                r_base_b <= cmd_base_b;
                r_len    <= cmd_len;
                r_idx    <= '0;
                r_chain  <= 1'b0;
            end
            if (r_state == S_EXEC) begin
                r_res_data  <= w_full[DATA_WIDTH-1:0];
                r_res_carry <= w_full[DATA_WIDTH];
                r_res_last  <= w_at_last;
                r_chain     <= w_full[DATA_WIDTH];
            end
            if (r_state == S_OUT && res_ready && !w_at_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_vector_engine.sv
// Directed table-driven bench for alu_vector_engine plus hand-written
// sequences for backpressure, mid-run reset and busy/write interactions.
module tb_alu_vector_engine;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en_a, wr_en_b;
    logic [3:0] wr_addr_a, wr_addr_b;
    logic [7:0] wr_data_a, wr_data_b;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_opcode, cmd_base_a, cmd_base_b, cmd_len;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_carry, res_last, busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_vector_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b), .cmd_len(cmd_len),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_last(res_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       op;
        logic [3:0]       ba;
        logic [3:0]       bb;
        logic [3:0]       len;
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][7:0]  ed;
        logic [3:0]       ec;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_both(input logic [3:0] aa, input logic [7:0] da,
                           input logic [3:0] ab, input logic [7:0] db);
        wr_en_a = 1'b1; wr_addr_a = aa; wr_data_a = da;
        wr_en_b = 1'b1; wr_addr_b = ab; wr_data_b = db;
        tick();
        wr_en_a = 1'b0; wr_en_b = 1'b0;
    endtask

    // Returns in the cycle after acceptance (T+1).
    task automatic send_cmd(input logic [3:0] op, input logic [3:0] ba,
                            input logic [3:0] bb, input logic [3:0] len, input string tag);
        int  n = 0;
        bit  ok = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
            else begin tick(); n++; end
        end
        check({tag, " cmd_ready wait"}, 32'(ok), 32'd1);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_base_a = ba; cmd_base_b = bb; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
        $display("cmd %s: op=%0d base_a=%0d base_b=%0d len=%0d", tag, op, ba, bb, len);
    endtask

    // start = cycles already elapsed since acceptance/handshake, counted from 1.
    task automatic expect_one(input logic [7:0] ed, input logic ec, input logic el,
                              input int start, input string tag);
        int cnt = start;
        bit got = 0;
        while (!got && cnt < 20) begin
            @(negedge clk);
            if (res_valid) got = 1;
            else begin tick(); cnt++; end
        end
        check({tag, " valid"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(cnt), 32'd3);
        check({tag, " data"}, 32'(res_data), 32'(ed));
        check({tag, " carry"}, 32'(res_carry), 32'(ec));
        check({tag, " last"}, 32'(res_last), 32'(el));
        $display("res %s: data=%02h carry=%0d last=%0d", tag, res_data, res_carry, res_last);
        tick();
    endtask

    task automatic expect_run(input vec_t v, input int start, input string tag);
        for (int e = 0; e <= int'(v.len); e++) begin
            expect_one(v.ed[e], v.ec[e], (e == int'(v.len)),
                       (e == 0) ? start : 1, $sformatf("%s e%0d", tag, e));
        end
        @(negedge clk);
        check({tag, " cmd_ready after"}, 32'(cmd_ready), 32'd1);
        check({tag, " valid dropped"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b1;
        wr_en_a = 1'b0; wr_en_b = 1'b0; wr_addr_a = '0; wr_addr_b = '0;
        wr_data_a = '0; wr_data_b = '0;
        cmd_opcode = '0; cmd_base_a = '0; cmd_base_b = '0; cmd_len = '0;

        vecs[0]  = '{op:4'd0,  ba:4'd0,  bb:4'd0, len:4'd0, a:32'h000000F0, b:32'h00000020, ed:32'h00000010, ec:4'b0001};
        vecs[1]  = '{op:4'd8,  ba:4'd2,  bb:4'd2, len:4'd2, a:32'h0001FFFF, b:32'h00000001, ed:32'h00020000, ec:4'b0011};
        vecs[2]  = '{op:4'd4,  ba:4'd14, bb:4'd0, len:4'd3, a:32'h04030201, b:32'h01010101, ed:32'h05020300, ec:4'b0000};
        vecs[3]  = '{op:4'd2,  ba:4'd5,  bb:4'd5, len:4'd0, a:32'h0000003C, b:32'h0000000F, ed:32'h0000000C, ec:4'b0000};
        vecs[4]  = '{op:4'd3,  ba:4'd5,  bb:4'd5, len:4'd0, a:32'h00000030, b:32'h00000005, ed:32'h00000035, ec:4'b0000};
        vecs[5]  = '{op:4'd5,  ba:4'd5,  bb:4'd5, len:4'd0, a:32'h0000005A, b:32'h000000FF, ed:32'h000000A5, ec:4'b0000};
        vecs[6]  = '{op:4'd6,  ba:4'd5,  bb:4'd5, len:4'd0, a:32'h00000081, b:32'h00000000, ed:32'h00000002, ec:4'b0001};
        vecs[7]  = '{op:4'd7,  ba:4'd5,  bb:4'd5, len:4'd0, a:32'h00000081, b:32'h00000000, ed:32'h00000040, ec:4'b0001};
        vecs[8]  = '{op:4'd9,  ba:4'd6,  bb:4'd6, len:4'd1, a:32'h00000100, b:32'h00000001, ed:32'h000000FF, ec:4'b0001};
        vecs[9]  = '{op:4'd12, ba:4'd5,  bb:4'd5, len:4'd0, a:32'h00000077, b:32'h00000011, ed:32'h00000000, ec:4'b0000};
        vecs[10] = '{op:4'd1,  ba:4'd8,  bb:4'd8, len:4'd1, a:32'h00001005, b:32'h00000307, ed:32'h00000DFE, ec:4'b0001};

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("cmd_ready in reset", 32'(cmd_ready), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset res_data", 32'(res_data), 32'd0);
        check("reset res_carry", 32'(res_carry), 32'd0);
        check("reset res_last", 32'(res_last), 32'd0);
        tick();

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            for (int k = 0; k <= int'(v.len); k++) begin
                wr_both(v.ba + 4'(k), v.a[k], v.bb + 4'(k), v.b[k]);
            end
            send_cmd(v.op, v.ba, v.bb, v.len, $sformatf("vec%0d", i));
            expect_run(v, 1, $sformatf("vec%0d", i));
        end

        // Backpressure: SUB 05-07 held for 4 stalled cycles
        wr_both(4'd7, 8'h05, 4'd7, 8'h07);
        res_ready = 1'b0;
        send_cmd(4'd1, 4'd7, 4'd7, 4'd0, "bp");
        tick(); tick();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check($sformatf("bp stall%0d valid", s), 32'(res_valid), 32'd1);
            check($sformatf("bp stall%0d data", s), 32'(res_data), 32'hFE);
            check($sformatf("bp stall%0d carry", s), 32'(res_carry), 32'd1);
            check($sformatf("bp stall%0d last", s), 32'(res_last), 32'd1);
            check($sformatf("bp stall%0d cmd_ready", s), 32'(cmd_ready), 32'd0);
            $display("bp stall %0d: data=%02h carry=%0d", s, res_data, res_carry);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp handshake data", 32'(res_data), 32'hFE);
        check("bp handshake valid", 32'(res_valid), 32'd1);
        tick();
        @(negedge clk);
        check("bp cmd_ready after", 32'(cmd_ready), 32'd1);
        check("bp valid dropped", 32'(res_valid), 32'd0);
        tick();

        // Reset mid-run
        for (int k = 0; k < 16; k++) wr_both(4'(k), 8'(k), 4'(k), 8'h01);
        send_cmd(4'd0, 4'd0, 4'd0, 4'd15, "rst");
        expect_one(8'h01, 1'b0, 1'b0, 1, "rst e0");
        expect_one(8'h02, 1'b0, 1'b0, 1, "rst e1");
        reset = 1'b1;
        @(negedge clk);
        check("rst mid cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst after cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst after valid", 32'(res_valid), 32'd0);
        check("rst after busy", 32'(busy), 32'd0);
        check("rst after data", 32'(res_data), 32'd0);
        check("rst after carry", 32'(res_carry), 32'd0);
        check("rst after last", 32'(res_last), 32'd0);
        $display("after mid-run reset: cmd_ready=%0d busy=%0d", cmd_ready, busy);
        tick();
        v = '{op:4'd0, ba:4'd3, bb:4'd3, len:4'd1, a:32'h0, b:32'h0, ed:32'h00000504, ec:4'b0000};
        send_cmd(v.op, v.ba, v.bb, v.len, "post_rst");
        expect_run(v, 1, "post_rst");
        tick();

        // Busy: ignored cmd_valid pulse, write in READ (old data) and earlier write (new data)
        wr_both(4'd9, 8'h0A, 4'd9, 8'h14);
        wr_both(4'd10, 8'h1E, 4'd10, 8'h28);
        send_cmd(4'd0, 4'd9, 4'd9, 4'd1, "busy");
        cmd_valid = 1'b1; cmd_opcode = 4'd2; cmd_base_a = 4'd0; cmd_base_b = 4'd0; cmd_len = 4'd0;
        wr_en_a = 1'b1; wr_addr_a = 4'd9;  wr_data_a = 8'h55;
        wr_en_b = 1'b1; wr_addr_b = 4'd10; wr_data_b = 8'h50;
        @(negedge clk);
        check("busy high", 32'(busy), 32'd1);
        check("busy cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        cmd_valid = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
        expect_one(8'h1E, 1'b0, 1'b0, 2, "busy e0");
        expect_one(8'h6E, 1'b0, 1'b1, 1, "busy e1");
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            check($sformatf("ignored cmd idle%0d", s), 32'(res_valid | busy), 32'd0);
            tick();
        end
        v = '{op:4'd0, ba:4'd9, bb:4'd9, len:4'd0, a:32'h0, b:32'h0, ed:32'h00000069, ec:4'b0000};
        send_cmd(v.op, v.ba, v.bb, v.len, "readback");
        expect_run(v, 1, "readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
